// File: rtl/seed_random_5_card_dealer.sv
// LFSR-driven card dealer: round-robin arbitration over N_CH requesters,
// rejection-sampled ranks 1..13, optional finite shoe with shuffle reload.
module seed_random_5_card_dealer #(
    parameter int                N_CH      = 2,
    parameter int                LFSR_W    = 16,
    parameter logic [LFSR_W-1:0] TAPS      = 16'hB400,
    parameter logic [LFSR_W-1:0] SEED      = 16'hACE1,
    parameter int                DECK_MODE = 1,
    parameter int                N_DECKS   = 1,
    localparam int               CH_W      = (N_CH > 1) ? $clog2(N_CH) : 1,
    localparam int               CL_W      = $clog2(52*N_DECKS+1),
    localparam int               RC_W      = $clog2(4*N_DECKS+1)
) (
    input  logic              clk_cd_i,
    input  logic              rst_cd_i,
    input  logic [N_CH-1:0]   req_i,
    input  logic              shuffle_i,
    output logic [N_CH-1:0]   ack_o,
    output logic              card_valid_o,
    output logic [3:0]        card_o,
    output logic [CH_W-1:0]   card_ch_o,
    output logic [CL_W-1:0]   cards_left_o,
    output logic              empty_o,
    output logic [1:0]        state_o
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] DRAW = 2'd1;
    localparam logic [1:0] SEND = 2'd2;

    localparam logic [LFSR_W-1:0] SEED_NZ   = (SEED == '0) ? LFSR_W'(1) : SEED;
    localparam logic [CL_W-1:0]   FULL_SHOE = CL_W'(52*N_DECKS);
    localparam logic [RC_W-1:0]   FULL_RANK = RC_W'(4*N_DECKS);
    localparam logic [CH_W:0]     N_CH_W    = (CH_W+1)'(N_CH);
    localparam bit                FINITE    = (DECK_MODE != 0);

    logic [1:0]        state;
    logic [LFSR_W-1:0] lfsr;
    logic [LFSR_W-1:0] lfsr_next;
    logic [CH_W-1:0]   rr_ptr;
    logic [CH_W-1:0]   rr_next;
    logic [CH_W-1:0]   grant;
    logic [N_CH-1:0]   req_rot;
    logic [CH_W-1:0]   arb_off;
    logic [CH_W:0]     arb_sum;
    logic [CH_W:0]     nxt_sum;
    logic [CH_W-1:0]   arb_sel;
    logic              arb_hit;
    logic [RC_W-1:0]   rank_cnt [16];
    logic [3:0]        cand;
    logic              cand_ok;

    assign lfsr_next = lfsr[0] ? ((lfsr >> 1) ^ TAPS) : (lfsr >> 1);
    assign cand      = lfsr[3:0];
    assign cand_ok   = (cand != 4'd0) && (cand <= 4'd13) &&
                       (!FINITE || (rank_cnt[cand] != '0));

    // Rotate requests so bit 0 is the RR pointer; the lowest set bit wins.
    always_comb begin
        req_rot = N_CH'({req_i, req_i} >> rr_ptr);
        arb_off = '0;
        arb_hit = 1'b0;
        for (int i = N_CH-1; i >= 0; i--) begin
            if (req_rot[i]) begin
                arb_off = CH_W'(i);
                arb_hit = 1'b1;
            end
        end
        arb_sum = {1'b0, rr_ptr} + {1'b0, arb_off};
        if (arb_sum >= N_CH_W) begin
            arb_sum = arb_sum - N_CH_W;
        end
        arb_sel = arb_sum[CH_W-1:0];
        nxt_sum = {1'b0, grant} + (CH_W+1)'(1);
        rr_next = (nxt_sum >= N_CH_W) ? '0 : nxt_sum[CH_W-1:0];
    end

    always_ff @(posedge clk_cd_i) begin
        if (rst_cd_i) begin
            state        <= IDLE;
            lfsr         <= SEED_NZ;
            rr_ptr       <= '0;
            grant        <= '0;
            card_o       <= '0;
            card_ch_o    <= '0;
            empty_o      <= 1'b0;
            cards_left_o <= FULL_SHOE;
            for (int r = 0; r < 16; r++) begin
                rank_cnt[r] <= (r >= 1 && r <= 13) ? FULL_RANK : '0;
            end
        end else begin
            lfsr <= lfsr_next;
            case (state)
                IDLE: begin
                    if (shuffle_i && FINITE) begin
                        cards_left_o <= FULL_SHOE;
                        empty_o      <= 1'b0;
                        for (int r = 0; r < 16; r++) begin
                            rank_cnt[r] <= (r >= 1 && r <= 13) ? FULL_RANK : '0;
                        end
                    end else if (arb_hit && !empty_o) begin
                        grant <= arb_sel;
                        state <= DRAW;
                    end
                end
                DRAW: begin
                    if (cand_ok) begin
                        card_o    <= cand;
                        card_ch_o <= grant;
                        if (FINITE) begin
                            rank_cnt[cand] <= rank_cnt[cand] - RC_W'(1);
                            cards_left_o   <= cards_left_o - CL_W'(1);
                        end
                        state <= SEND;
                    end
                end
                SEND: begin
                    rr_ptr <= rr_next;
                    if (FINITE && cards_left_o == '0) begin
                        empty_o <= 1'b1;
                    end
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign state_o      = state;
    assign card_valid_o = (state == SEND);
    assign ack_o        = card_valid_o ? (N_CH'(1) << grant) : '0;

endmodule
